hazard_fwd_unit: RTL

//  Parametrised hazard and forwarding controller for the miniRV in-order pipeline (IF/ID/EX/MEM/WB and deeper variants).
//  It holds a scoreboard of in-flight register writes behind ID and resolves ID-stage operand forwarding.
//  It also detects load-use hazards (stalls IF/ID and inserts EX bubbles) and flushes wrong-path instructions on an EX redirect.

---
 rtl/hazard_fwd_unit.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: ID-side scoreboard of in-flight writes, operand forwarding,
// load-use stall and redirect flush control for the miniRV pipeline.
// Optional feature: define HAZARD_PERF_EN to build the stall/flush perf counters.
module hazard_fwd_unit #(
    parameter  int unsigned XLEN      = 32,
    parameter  int unsigned REG_AW    = 5,
    parameter  int unsigned FWD_DEPTH = 3,
    parameter  int unsigned LOAD_RDY  = 1,
    localparam int unsigned SELW      = $clog2(FWD_DEPTH + 1)
) (
    input  logic                      clk_cpu,
    input  logic                      rst_n_i,
    input  logic                      id_valid_i,
    input  logic [REG_AW-1:0]         id_rs1_i,
    input  logic [REG_AW-1:0]         id_rs2_i,
    input  logic                      id_rs1_use_i,
    input  logic                      id_rs2_use_i,
    input  logic [REG_AW-1:0]         id_rd_i,
    input  logic                      id_rf_we_i,
    input  logic                      id_is_load_i,
    input  logic                      ex_redirect_i,
    input  logic [FWD_DEPTH*XLEN-1:0] stage_wdata_i,
    output logic [SELW-1:0]           fwd_sel_rs1_o,
    output logic [SELW-1:0]           fwd_sel_rs2_o,
    output logic [XLEN-1:0]           fwd_data_rs1_o,
    output logic [XLEN-1:0]           fwd_data_rs2_o,
    output logic                      stall_o,
    output logic                      flush_if_id_o,
    output logic                      flush_id_ex_o,
    output logic [31:0]               stall_cnt_o,
    output logic [31:0]               flush_cnt_o
);

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              we;
        logic              is_load;
    } sb_entry_t;

    sb_entry_t sb_q [FWD_DEPTH];
    sb_entry_t sb_d [FWD_DEPTH];

    // Low from reset until the first clock edge after release; masks all controls.
    logic live_q;
    logic live_d;

    logic            hit_rs1;
    logic            hit_rs2;
    logic            early_ld_rs1;
    logic            early_ld_rs2;
    logic [SELW-1:0] idx_rs1;
    logic [SELW-1:0] idx_rs2;
    logic [XLEN-1:0] data_rs1;
    logic [XLEN-1:0] data_rs2;
    logic            redirect;
    logic            load_use;

    function automatic logic src_match(input sb_entry_t e, input logic [REG_AW-1:0] rs,
                                       input logic use_src, input logic id_valid);
        return e.valid & e.we & (e.rd != '0) & (e.rd == rs) & use_src & id_valid;
    endfunction

    // Youngest-match search per source: walk oldest to youngest so the lowest k wins.
    always_comb begin
        hit_rs1      = 1'b0;
        hit_rs2      = 1'b0;
        early_ld_rs1 = 1'b0;
        early_ld_rs2 = 1'b0;
        idx_rs1      = '0;
        idx_rs2      = '0;
        data_rs1     = '0;
        data_rs2     = '0;
        for (int k = int'(FWD_DEPTH) - 1; k >= 0; k--) begin
            if (src_match(sb_q[k], id_rs1_i, id_rs1_use_i, id_valid_i)) begin
                hit_rs1      = 1'b1;
                idx_rs1      = SELW'(k + 1);
                data_rs1     = stage_wdata_i[k*int'(XLEN) +: XLEN];
                early_ld_rs1 = sb_q[k].is_load & (k < int'(LOAD_RDY));
            end
            if (src_match(sb_q[k], id_rs2_i, id_rs2_use_i, id_valid_i)) begin
                hit_rs2      = 1'b1;
                idx_rs2      = SELW'(k + 1);
                data_rs2     = stage_wdata_i[k*int'(XLEN) +: XLEN];
                early_ld_rs2 = sb_q[k].is_load & (k < int'(LOAD_RDY));
            end
        end
    end

    // Hazard and forwarding outputs; a redirect overrides a load-use stall.
    always_comb begin
        redirect       = live_q & ex_redirect_i;
        load_use       = live_q & (early_ld_rs1 | early_ld_rs2);
        stall_o        = load_use & ~redirect;
        flush_if_id_o  = redirect;
        flush_id_ex_o  = redirect | load_use;
        fwd_sel_rs1_o  = '0;
        fwd_sel_rs2_o  = '0;
        fwd_data_rs1_o = '0;
        fwd_data_rs2_o = '0;
        if (live_q & hit_rs1 & ~early_ld_rs1) begin
            fwd_sel_rs1_o  = idx_rs1;
            fwd_data_rs1_o = data_rs1;
        end
        if (live_q & hit_rs2 & ~early_ld_rs2) begin
            fwd_sel_rs2_o  = idx_rs2;
            fwd_data_rs2_o = data_rs2;
        end
    end

    // Next scoreboard: shift one stage down, insert ID or a bubble at the top.
    always_comb begin
        live_d = 1'b1;
        sb_d[0] = '0;
        if (id_valid_i & ~stall_o & ~redirect) begin
            sb_d[0].valid   = 1'b1;
            sb_d[0].rd      = id_rd_i;
            sb_d[0].we      = id_rf_we_i;
            sb_d[0].is_load = id_is_load_i;
        end
        for (int k = 1; k < int'(FWD_DEPTH); k++) begin
            sb_d[k] = sb_q[k-1];
        end
    end

    // Scoreboard register; cleared immediately on reset.
    always_ff @(posedge clk_cpu or negedge rst_n_i) begin
        if (!rst_n_i) begin
            live_q <= 1'b0;
            for (int k = 0; k < int'(FWD_DEPTH); k++) begin
                sb_q[k] <= '0;
            end
        end else begin
            live_q <= live_d;
            for (int k = 0; k < int'(FWD_DEPTH); k++) begin
                sb_q[k] <= sb_d[k];
            end
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;
    logic [31:0] flush_cnt_q;
    logic [31:0] flush_cnt_d;

    // Saturating event counters.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_o && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (redirect && (flush_cnt_q != 32'hFFFF_FFFF)) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk_cpu or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`else
    assign stall_cnt_o = 32'h0;
    assign flush_cnt_o = 32'h0;
`endif

endmodule
